// File: rtl/imu_pkg.sv
// Shared types and constants for the IMU interface: FSM state encoding,
// the fixed SPI command words, and the saturating offset subtraction used
// when the yaw offset build option (IMU_YAW_OFFSET_EN) is enabled.
package imu_pkg;

   typedef enum logic [2:0] {
      RST_WAIT,
      CFG1,
      CFG2,
      CFG3,
      IDLE,
      RD_L,
      RD_H
   } imu_state_t;

   localparam logic [15:0] CMD_CFG1 = 16'h0D02;
   localparam logic [15:0] CMD_CFG2 = 16'h1160;
   localparam logic [15:0] CMD_CFG3 = 16'h1440;
   localparam logic [15:0] CMD_RD_L = 16'hA600;
   localparam logic [15:0] CMD_RD_H = 16'hA700;

`ifdef IMU_YAW_OFFSET_EN
   // raw - off in 17 bits; bits 16 and 15 disagree only on overflow
   function automatic logic [15:0] sat_sub(input logic [15:0] raw,
                                           input logic [15:0] off);
      logic [16:0] diff;
      diff = {raw[15], raw} - {off[15], off};
      if (diff[16] != diff[15]) begin
         sat_sub = diff[16] ? 16'h8000 : 16'h7FFF;
      end else begin
         sat_sub = diff[15:0];
      end
   endfunction
`endif

endpackage

// File: rtl/imu_int_sync.sv
// Brings the sensor data-ready line into the clk domain through two flops
// and flags a rising edge of the synchronized level with a third flop.
module imu_int_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic int_async,
   output logic int_rise
);

   logic sync1;
   logic sync2;
   logic sync3;

   // Two-stage synchronizer followed by one history flop for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
      end else begin
         sync1 <= int_async;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   assign int_rise = sync2 & ~sync3;

endmodule

// File: rtl/imu_intf.sv
// IMU SPI front end: waits out sensor power-up, writes three configuration
// registers, then reads the 16-bit yaw rate (low byte then high byte) each
// time the sensor raises INT. Every SPI step advances only on a rising edge
// of done, so a done level left high from the previous transfer is ignored.
// Build option IMU_YAW_OFFSET_EN adds a yaw_off input that is subtracted
// (with saturation) from the raw reading before it appears on yaw_rt.
module imu_intf
   import imu_pkg::*;
#(
   parameter int RST_WAIT_W = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        INT,
   input  logic        done,
   input  logic [7:0]  inert_data,
`ifdef IMU_YAW_OFFSET_EN
   input  logic [15:0] yaw_off,
`endif
   output logic        wrt,
   output logic [15:0] cmd,
   output logic [15:0] yaw_rt,
   output logic        vld,
   output logic        init_cmplt
);

   imu_state_t            state;
   imu_state_t            state_nxt;
   logic [RST_WAIT_W-1:0] wait_cnt;
   logic                  done_q;
   logic                  done_rise;
   logic                  int_rise;
   logic                  pending;
   logic [7:0]            low_byte;
   logic [15:0]           yaw_calc;
   logic                  start;
   logic [15:0]           cmd_nxt;
   logic                  lat_lo;
   logic                  lat_hi;
   logic                  set_init;

   imu_int_sync u_int_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .int_async (INT),
      .int_rise  (int_rise)
   );

   assign done_rise = done & ~done_q;

`ifdef IMU_YAW_OFFSET_EN
   assign yaw_calc = sat_sub({inert_data, low_byte}, yaw_off);
`else
   assign yaw_calc = {inert_data, low_byte};
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RST_WAIT;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state plus the one-cycle strobes that launch commands and capture data
   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      cmd_nxt   = cmd;
      lat_lo    = 1'b0;
      lat_hi    = 1'b0;
      set_init  = 1'b0;
      case (state)
         RST_WAIT: begin
            if (&wait_cnt) begin
               state_nxt = CFG1;
               start     = 1'b1;
               cmd_nxt   = CMD_CFG1;
            end
         end
         CFG1: begin
            if (done_rise) begin
               state_nxt = CFG2;
               start     = 1'b1;
               cmd_nxt   = CMD_CFG2;
            end
         end
         CFG2: begin
            if (done_rise) begin
               state_nxt = CFG3;
               start     = 1'b1;
               cmd_nxt   = CMD_CFG3;
            end
         end
         CFG3: begin
            if (done_rise) begin
               state_nxt = IDLE;
               set_init  = 1'b1;
            end
         end
         IDLE: begin
            if (int_rise || pending) begin
               state_nxt = RD_L;
               start     = 1'b1;
               cmd_nxt   = CMD_RD_L;
            end
         end
         RD_L: begin
            if (done_rise) begin
               state_nxt = RD_H;
               start     = 1'b1;
               cmd_nxt   = CMD_RD_H;
               lat_lo    = 1'b1;
            end
         end
         RD_H: begin
            if (done_rise) begin
               state_nxt = IDLE;
               lat_hi    = 1'b1;
            end
         end
         default: begin
            state_nxt = RST_WAIT;
         end
      endcase
   end

   // Power-up wait counter, only running while in RST_WAIT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
      end else if (state == RST_WAIT) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // Previous-cycle copy of done for rising-edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_q <= 1'b0;
      end else begin
         done_q <= done;
      end
   end

   // One-deep memory of an INT edge that arrived while busy; consumed on entry to RD_L
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= 1'b0;
      end else if (state == IDLE && state_nxt == RD_L) begin
         pending <= 1'b0;
      end else if (int_rise && init_cmplt && state != IDLE) begin
         pending <= 1'b1;
      end
   end

   // Registered outputs: command launch, byte capture, yaw update and init flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrt        <= 1'b0;
         cmd        <= 16'h0000;
         low_byte   <= 8'h00;
         yaw_rt     <= 16'h0000;
         vld        <= 1'b0;
         init_cmplt <= 1'b0;
      end else begin
         wrt <= start;
         vld <= lat_hi;
         if (start) begin
            cmd <= cmd_nxt;
         end
         if (lat_lo) begin
            low_byte <= inert_data;
         end
         if (lat_hi) begin
            yaw_rt <= yaw_calc;
         end
         if (set_init) begin
            init_cmplt <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_imu_intf.sv
// Directed testbench for imu_intf with a 16-cycle power-up wait. Acts as the
// SPI master's done/inert_data responder and drives INT pulses; expected
// values are hand-computed constants. Define IMU_YAW_OFFSET_EN to also
// exercise the saturating yaw offset.
module tb_imu_intf;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        INT = 1'b0;
   logic        done = 1'b0;
   logic [7:0]  inert_data = 8'h00;
   logic        wrt;
   logic [15:0] cmd;
   logic [15:0] yaw_rt;
   logic        vld;
   logic        init_cmplt;
`ifdef IMU_YAW_OFFSET_EN
   logic [15:0] yaw_off = 16'h0000;
`endif

   int checks = 0;
   int errors = 0;

   imu_intf #(.RST_WAIT_W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .INT        (INT),
      .done       (done),
      .inert_data (inert_data),
`ifdef IMU_YAW_OFFSET_EN
      .yaw_off    (yaw_off),
`endif
      .wrt        (wrt),
      .cmd        (cmd),
      .yaw_rt     (yaw_rt),
      .vld        (vld),
      .init_cmplt (init_cmplt)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Hard stop in case something hangs outside the bounded waits
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait up to max cycles for wrt; cycles reports how many ticks were needed
   task automatic wait_wrt(input int max, output bit seen, output int cycles);
      seen = 1'b0;
      cycles = 0;
      while (cycles < max) begin
         if (wrt) begin
            seen = 1'b1;
            break;
         end
         tick();
         cycles++;
      end
   endtask

   // SPI side: drop done, wait, then raise done with the read byte for one edge
   task automatic respond(input logic [7:0] data, input int delay);
      done = 1'b0;
      repeat (delay) tick();
      inert_data = data;
      done = 1'b1;
      tick();
   endtask

   // Sensor side: a two-cycle INT pulse
   task automatic pulse_int();
      INT = 1'b1;
      tick();
      tick();
      INT = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      checks++; if (wrt !== 1'b0) begin errors++; $display("[TB] FAIL reset_wrt: got %b expected 0", wrt); end
      checks++; if (cmd !== 16'h0000) begin errors++; $display("[TB] FAIL reset_cmd: got %h expected 0000", cmd); end
      checks++; if (yaw_rt !== 16'h0000) begin errors++; $display("[TB] FAIL reset_yaw: got %h expected 0000", yaw_rt); end
      checks++; if (vld !== 1'b0) begin errors++; $display("[TB] FAIL reset_vld: got %b expected 0", vld); end
      checks++; if (init_cmplt !== 1'b0) begin errors++; $display("[TB] FAIL reset_init: got %b expected 0", init_cmplt); end
   endtask

   task automatic test_config();
      bit seen;
      int cyc;
      rst_n = 1'b1;
      INT = 1'b1;
      tick();
      tick();
      INT = 1'b0;
      tick();
      tick();
      wait_wrt(40, seen, cyc);
      checks++; if (!seen || cyc != 12) begin errors++; $display("[TB] FAIL cfg1_wait: got %0d cycles (seen=%b) expected 12 after 4", cyc, seen); end
      checks++; if (cmd !== 16'h0D02) begin errors++; $display("[TB] FAIL cfg1_cmd: got %h expected 0d02", cmd); end
      tick();
      checks++; if (wrt !== 1'b0) begin errors++; $display("[TB] FAIL cfg1_wrt_width: got %b expected 0", wrt); end
      checks++; if (cmd !== 16'h0D02) begin errors++; $display("[TB] FAIL cfg1_cmd_hold: got %h expected 0d02", cmd); end
      respond(8'h00, 2);
      checks++; if (wrt !== 1'b1 || cmd !== 16'h1160) begin errors++; $display("[TB] FAIL cfg2: got wrt=%b cmd=%h expected 1 1160", wrt, cmd); end
      INT = 1'b1;
      respond(8'h00, 2);
      checks++; if (wrt !== 1'b1 || cmd !== 16'h1440) begin errors++; $display("[TB] FAIL cfg3: got wrt=%b cmd=%h expected 1 1440", wrt, cmd); end
      checks++; if (init_cmplt !== 1'b0) begin errors++; $display("[TB] FAIL init_early: got %b expected 0", init_cmplt); end
      INT = 1'b0;
      respond(8'h00, 2);
      checks++; if (init_cmplt !== 1'b1) begin errors++; $display("[TB] FAIL init_cmplt: got %b expected 1", init_cmplt); end
      wait_wrt(12, seen, cyc);
      checks++; if (seen) begin errors++; $display("[TB] FAIL early_int_ignored: got wrt after %0d cycles expected none", cyc); end
   endtask

   task automatic test_read();
      bit seen;
      int cyc;
      pulse_int();
      wait_wrt(8, seen, cyc);
      checks++; if (!seen || cmd !== 16'hA600) begin errors++; $display("[TB] FAIL rd_l_cmd: got seen=%b cmd=%h expected 1 a600", seen, cmd); end
      respond(8'h34, 3);
      checks++; if (wrt !== 1'b1 || cmd !== 16'hA700) begin errors++; $display("[TB] FAIL rd_h_cmd: got wrt=%b cmd=%h expected 1 a700", wrt, cmd); end
      checks++; if (vld !== 1'b0 || yaw_rt !== 16'h0000) begin errors++; $display("[TB] FAIL yaw_hold: got vld=%b yaw=%h expected 0 0000", vld, yaw_rt); end
      respond(8'h12, 1);
      checks++; if (vld !== 1'b1) begin errors++; $display("[TB] FAIL read_vld: got %b expected 1", vld); end
      checks++; if (yaw_rt !== 16'h1234) begin errors++; $display("[TB] FAIL read_yaw: got %h expected 1234", yaw_rt); end
      checks++; if (wrt !== 1'b0) begin errors++; $display("[TB] FAIL read_idle_wrt: got %b expected 0", wrt); end
      tick();
      checks++; if (vld !== 1'b0 || yaw_rt !== 16'h1234) begin errors++; $display("[TB] FAIL read_vld_width: got vld=%b yaw=%h expected 0 1234", vld, yaw_rt); end
   endtask

   task automatic test_back_to_back();
      bit seen;
      int cyc;
      pulse_int();
      wait_wrt(8, seen, cyc);
      checks++; if (!seen || cmd !== 16'hA600) begin errors++; $display("[TB] FAIL b2b_rd_l: got seen=%b cmd=%h expected 1 a600", seen, cmd); end
      respond(8'h78, 1);
      checks++; if (cmd !== 16'hA700) begin errors++; $display("[TB] FAIL b2b_rd_h: got %h expected a700", cmd); end
      repeat (3) begin
         INT = 1'b1;
         tick();
         tick();
         INT = 1'b0;
         tick();
         tick();
      end
      checks++; if (cmd !== 16'hA700) begin errors++; $display("[TB] FAIL b2b_no_preempt: got %h expected a700", cmd); end
      respond(8'h56, 4);
      checks++; if (vld !== 1'b1 || yaw_rt !== 16'h5678) begin errors++; $display("[TB] FAIL b2b_yaw1: got vld=%b yaw=%h expected 1 5678", vld, yaw_rt); end
      tick();
      checks++; if (wrt !== 1'b1 || cmd !== 16'hA600) begin errors++; $display("[TB] FAIL b2b_pending_start: got wrt=%b cmd=%h expected 1 a600", wrt, cmd); end
      respond(8'h01, 1);
      respond(8'h00, 1);
      checks++; if (vld !== 1'b1 || yaw_rt !== 16'h0001) begin errors++; $display("[TB] FAIL b2b_yaw2: got vld=%b yaw=%h expected 1 0001", vld, yaw_rt); end
      wait_wrt(15, seen, cyc);
      checks++; if (seen) begin errors++; $display("[TB] FAIL b2b_single_extra: got wrt after %0d cycles expected none", cyc); end
   endtask

   task automatic test_done_held();
      bit seen;
      int cyc;
      bit any_wrt;
      pulse_int();
      wait_wrt(8, seen, cyc);
      checks++; if (!seen || cmd !== 16'hA600) begin errors++; $display("[TB] FAIL held_rd_l: got seen=%b cmd=%h expected 1 a600", seen, cmd); end
      any_wrt = 1'b0;
      tick();
      any_wrt |= wrt;
      tick();
      any_wrt |= wrt;
      done = 1'b0;
      repeat (4) begin
         tick();
         any_wrt |= wrt;
      end
      checks++; if (any_wrt || cmd !== 16'hA600) begin errors++; $display("[TB] FAIL held_no_advance: got wrt_seen=%b cmd=%h expected 0 a600", any_wrt, cmd); end
      inert_data = 8'h9A;
      done = 1'b1;
      tick();
      checks++; if (wrt !== 1'b1 || cmd !== 16'hA700) begin errors++; $display("[TB] FAIL held_fresh_edge: got wrt=%b cmd=%h expected 1 a700", wrt, cmd); end
      respond(8'hBC, 1);
      checks++; if (vld !== 1'b1 || yaw_rt !== 16'hBC9A) begin errors++; $display("[TB] FAIL held_yaw: got vld=%b yaw=%h expected 1 bc9a", vld, yaw_rt); end
   endtask

   task automatic test_reset_mid();
      bit seen;
      int cyc;
      pulse_int();
      wait_wrt(8, seen, cyc);
      checks++; if (!seen || cmd !== 16'hA600) begin errors++; $display("[TB] FAIL mid_rd_l: got seen=%b cmd=%h expected 1 a600", seen, cmd); end
      rst_n = 1'b0;
      #2;
      checks++; if (wrt !== 1'b0 || cmd !== 16'h0000) begin errors++; $display("[TB] FAIL mid_rst_cmd: got wrt=%b cmd=%h expected 0 0000", wrt, cmd); end
      checks++; if (yaw_rt !== 16'h0000 || vld !== 1'b0 || init_cmplt !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_out: got yaw=%h vld=%b init=%b expected 0000 0 0", yaw_rt, vld, init_cmplt); end
      tick();
      rst_n = 1'b1;
      wait_wrt(40, seen, cyc);
      checks++; if (!seen || cyc != 16 || cmd !== 16'h0D02) begin errors++; $display("[TB] FAIL mid_restart: got %0d cycles cmd=%h expected 16 0d02", cyc, cmd); end
      respond(8'h00, 1);
      respond(8'h00, 1);
      respond(8'h00, 1);
      checks++; if (init_cmplt !== 1'b1) begin errors++; $display("[TB] FAIL mid_reinit: got %b expected 1", init_cmplt); end
   endtask

`ifdef IMU_YAW_OFFSET_EN
   task automatic test_offset();
      bit seen;
      int cyc;
      yaw_off = 16'h0010;
      pulse_int();
      wait_wrt(8, seen, cyc);
      respond(8'h05, 1);
      respond(8'h80, 1);
      checks++; if (!seen || yaw_rt !== 16'h8000) begin errors++; $display("[TB] FAIL off_neg_sat: got %h expected 8000", yaw_rt); end
      tick();
      pulse_int();
      wait_wrt(8, seen, cyc);
      respond(8'h20, 1);
      respond(8'h00, 1);
      checks++; if (!seen || vld !== 1'b1 || yaw_rt !== 16'h0010) begin errors++; $display("[TB] FAIL off_plain: got vld=%b yaw=%h expected 1 0010", vld, yaw_rt); end
      yaw_off = 16'hFFF0;
      tick();
      pulse_int();
      wait_wrt(8, seen, cyc);
      respond(8'hF5, 1);
      respond(8'h7F, 1);
      checks++; if (!seen || yaw_rt !== 16'h7FFF) begin errors++; $display("[TB] FAIL off_pos_sat: got %h expected 7fff", yaw_rt); end
   endtask
`endif

   initial begin
      test_reset();
      test_config();
      test_read();
      test_back_to_back();
      test_done_held();
      test_reset_mid();
`ifdef IMU_YAW_OFFSET_EN
      test_offset();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/imu_intf.md
IMU_INTF -- requirements
Module: imu_intf

Interface
REQ-001 Parameter: RST_WAIT_W, default 16, width of power-up wait counter; wait length is 2^RST_WAIT_W clk cycles.
REQ-002 clk  input  1  system clock; all flops on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 INT  input  1  sensor data-ready, asynchronous to clk.
REQ-005 done  input  1  SPI transaction complete; level, held until next wrt.
REQ-006 inert_data  input  8  SPI read byte (low byte of SPI rd_data).
REQ-007 wrt  output  1  single-cycle SPI start pulse.
REQ-008 cmd  output  16  SPI command word; bit15=1 read, bits14:8 addr, bits7:0 write data.
REQ-009 yaw_rt  output  16  signed yaw rate {high byte, low byte}.
REQ-010 vld  output  1  single-cycle pulse: yaw_rt updated.
REQ-011 init_cmplt  output  1  level high once the configuration writes are done.

Function
REQ-012 States: RST_WAIT, CFG1, CFG2, CFG3, IDLE, RD_L, RD_H.
REQ-013 RST_WAIT: counter increments each clk; on all-ones, go to CFG1.
REQ-014 wrt SHALL pulse for exactly one cycle on entry to each of CFG1-3, RD_L, RD_H, with cmd valid that cycle and held until the next wrt.
REQ-015 Commands: CFG1=0x0D02, CFG2=0x1160, CFG3=0x1440, RD_L=0xA600, RD_H=0xA700.
REQ-016 Completion = done rising edge (done high, prior-cycle done low); a high done level without an edge SHALL NOT advance state.
REQ-017 CFG1->CFG2->CFG3->IDLE, each on completion; init_cmplt set on the CFG3->IDLE transition.
REQ-018 INT passes a two-flop synchronizer; a rising edge on the synchronized INT SHALL be detected (3 flops total).
REQ-019 IDLE + INT edge (or pending flag set) -> RD_L; RD_L completion latches inert_data into low byte and goes to RD_H; RD_H completion latches the high byte and returns to IDLE.
REQ-020 yaw_rt SHALL update and vld pulse in the cycle after the RD_H done edge; yaw_rt holds its value otherwise.
REQ-021 An INT edge outside IDLE sets a one-deep pending flag, cleared on entry to RD_L; further edges while pending are dropped.
REQ-022 INT edges before init_cmplt SHALL be ignored and SHALL NOT set pending.
REQ-023 No timeout: a missing done edge holds the state indefinitely.

Reset
REQ-024 rst_n low: state=RST_WAIT, counter=0, wrt=0, cmd=0, yaw_rt=0, vld=0, init_cmplt=0, pending=0, sync and edge flops=0, done history=0.
REQ-025 Reset mid-transaction aborts it; after release the full wait and configuration sequence repeats.

Configuration
REQ-026 Macro IMU_YAW_OFFSET_EN: when defined, adds input yaw_off [15:0] (signed); yaw_rt = raw - yaw_off, saturated to 0x7FFF/0x8000, latency unchanged.
REQ-027 When IMU_YAW_OFFSET_EN is undefined, the yaw_off port does not exist and yaw_rt = raw.

Structure
REQ-028 Package imu_pkg SHALL hold the state enum type and the five command constants.
REQ-029 Sub-module imu_int_sync SHALL implement the synchronizer and rising-edge detector; everything else is in imu_intf.

Verification (RST_WAIT_W=4 for sim)
REQ-030 Reset release -> after 16 cycles wrt pulses with cmd=0x0D02; done edges are returned -> 0x1160, 0x1440 follow; init_cmplt=1 after the third done edge.
REQ-031 After init, INT pulse; reads return 0x34 then 0x12 -> cmd 0xA600 then 0xA700; yaw_rt=0x1234 and one-cycle vld one cycle after the second done edge.
REQ-032 INT edge during RD_H -> a second RD_L starts immediately after return to IDLE; three edges during one read -> exactly one extra read.
REQ-033 done held high across the wrt cycle and the next two cycles before dropping -> no state advance until a fresh done edge.
REQ-034 rst_n asserted in RD_L -> all outputs return to reset values; the sequence restarts with cmd=0x0D02.
REQ-035 IMU_YAW_OFFSET_EN defined, yaw_off=0x0010, raw 0x8005 -> yaw_rt=0x8000 (saturated); raw 0x0020 -> 0x0010.
